raystore_writer: RTL and testbench

- Write-side front end for the ray store.
- Accepts new ray vectors from the ray generator with sideband data and allocates a free rayID for each from an internal free list.
- Drives the ray store write port (we/waddr/wdata) and forwards the rayID plus sideband downstream, so traversal can later read the ray back by ID.
- Retired rayIDs return through a free port and are recycled.

---
 rtl/raystore_writer_pkg.sv | 18 +
 rtl/raystore_writer_rayid_fifo.sv | 54 +++++
 rtl/raystore_writer.sv | 119 +++++++++++
 tb/tb_raystore_writer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raystore_writer_pkg.sv
// Shared ray store types: ray ID, packed ray vector, writer FSM encoding.
package raystore_writer_pkg;

  typedef logic [4:0] rayID_t;

  typedef struct packed {
    logic [11:0] org_x;
    logic [11:0] org_y;
    logic [11:0] dir_x;
    logic [11:0] dir_y;
  } ray_vec_t;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } raystore_writer_state_t;

endpackage

// File: rtl/raystore_writer_rayid_fifo.sv
// Circular rayID FIFO with count; push into a full FIFO and pop from an empty one are ignored.
// Head data is combinational from the read pointer; a push becomes visible at the head the next cycle.
module rayid_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push   = push && (count != CW'(DEPTH));
  assign do_pop    = pop && (count != '0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/raystore_writer.sv
// Ray store write front end: allocates a free rayID per incoming ray, writes the store, forwards ID+sideband (1-cycle latency).
// Stalls upstream while initialising, out of IDs, or held by ds_stall. RAYSTORE_WRITER_CHK_EN enables double-free detection.
module raystore_writer
  import raystore_writer_pkg::*;
#(
  parameter int SB_WIDTH = 8,
  parameter int NUM_RAYS = 2**$bits(rayID_t)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          us_valid,
  input  logic [$bits(ray_vec_t)-1:0]   us_ray,
  input  logic [SB_WIDTH-1:0]           us_sb_data,
  output logic                          us_stall,
  output logic                          we,
  output logic [$bits(rayID_t)-1:0]     waddr,
  output logic [$bits(ray_vec_t)-1:0]   wdata,
  output logic                          ds_valid,
  output logic [$bits(rayID_t)-1:0]     ds_rayID,
  output logic [SB_WIDTH-1:0]           ds_sb_data,
  input  logic                          ds_stall,
  input  logic                          free_valid,
  input  logic [$bits(rayID_t)-1:0]     free_rayID,
  output logic [$clog2(NUM_RAYS+1)-1:0] free_cnt,
  output logic                          init_done,
  output logic                          err_double_free
);

  localparam int IDW = $bits(rayID_t);
  localparam logic [0:0] S_INIT = INIT;
  localparam logic [0:0] S_RUN  = RUN;

  logic [0:0]     state;
  logic [IDW-1:0] init_id;
  logic           running;
  logic           accept;
  logic           free_ok;
  logic           fl_push;
  logic [IDW-1:0] fl_push_id;
  logic [IDW-1:0] fl_head;

  assign running   = (state == S_RUN);
  assign init_done = running;
  assign us_stall  = !running || (free_cnt == '0) || (ds_valid && ds_stall);
  assign accept    = us_valid && !us_stall;

  // While initialising the counter owns the push port and frees are ignored.
  assign fl_push    = running ? (free_valid && free_ok) : 1'b1;
  assign fl_push_id = running ? free_rayID : init_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_INIT;
      init_id <= '0;
    end else if (!running) begin
      init_id <= init_id + 1'b1;
      if (init_id == IDW'(NUM_RAYS-1)) state <= S_RUN;
    end
  end

  rayid_fifo #(
    .DEPTH (NUM_RAYS),
    .WIDTH (IDW)
  ) u_free_list (
    .clk       (clk),
    .rst       (rst),
    .push      (fl_push),
    .push_data (fl_push_id),
    .pop       (accept),
    .head_data (fl_head),
    .count     (free_cnt)
  );

  // accept implies the output slot is empty or draining this cycle, so overwrite is safe.
  always_ff @(posedge clk) begin
    if (rst) begin
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      ds_valid   <= 1'b0;
      ds_rayID   <= '0;
      ds_sb_data <= '0;
    end else begin
      we <= accept;
      if (accept) begin
        waddr      <= fl_head;
        wdata      <= us_ray;
        ds_valid   <= 1'b1;
        ds_rayID   <= fl_head;
        ds_sb_data <= us_sb_data;
      end else if (!ds_stall) begin
        ds_valid <= 1'b0;
      end
    end
  end

`ifdef RAYSTORE_WRITER_CHK_EN
  logic [NUM_RAYS-1:0] alloc_map;

  assign free_ok = alloc_map[free_rayID];

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_map       <= '0;
      err_double_free <= 1'b0;
    end else begin
      if (running && free_valid) begin
        if (alloc_map[free_rayID]) alloc_map[free_rayID] <= 1'b0;
        else                       err_double_free       <= 1'b1;
      end
      if (accept) alloc_map[fl_head] <= 1'b1;
    end
  end
`else
  assign free_ok         = 1'b1;
  assign err_double_free = 1'b0;
`endif

endmodule

// File: tb/tb_raystore_writer.sv
// Bench for raystore_writer: directed vector table, corner sequences, random traffic vs a queue-based model.
`timescale 1ns/1ps
module tb_raystore_writer;
  import raystore_writer_pkg::*;

  localparam int N   = 32;
  localparam int SBW = 8;
  localparam int IDW = $bits(rayID_t);
  localparam int VW  = $bits(ray_vec_t);
  localparam int CW  = $clog2(N+1);

  logic           clk = 1'b0;
  logic           rst;
  logic           us_valid;
  logic [VW-1:0]  us_ray;
  logic [SBW-1:0] us_sb_data;
  logic           us_stall;
  logic           we;
  logic [IDW-1:0] waddr;
  logic [VW-1:0]  wdata;
  logic           ds_valid;
  logic [IDW-1:0] ds_rayID;
  logic [SBW-1:0] ds_sb_data;
  logic           ds_stall;
  logic           free_valid;
  logic [IDW-1:0] free_rayID;
  logic [CW-1:0]  free_cnt;
  logic           init_done;
  logic           err_double_free;

  always #5 clk = ~clk;

  raystore_writer #(.SB_WIDTH(SBW), .NUM_RAYS(N)) dut (
    .clk(clk), .rst(rst),
    .us_valid(us_valid), .us_ray(us_ray), .us_sb_data(us_sb_data), .us_stall(us_stall),
    .we(we), .waddr(waddr), .wdata(wdata),
    .ds_valid(ds_valid), .ds_rayID(ds_rayID), .ds_sb_data(ds_sb_data), .ds_stall(ds_stall),
    .free_valid(free_valid), .free_rayID(free_rayID),
    .free_cnt(free_cnt), .init_done(init_done), .err_double_free(err_double_free)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: free list as a queue of IDs plus the expected output registers.
  int             free_q[$];
  bit             running;
  int             init_k;
  bit             alloc_m [N];
  logic           exp_we;
  logic [IDW-1:0] exp_waddr;
  logic [VW-1:0]  exp_wdata;
  logic           exp_dsv;
  logic [IDW-1:0] exp_dsid;
  logic [SBW-1:0] exp_dssb;
  logic           exp_err;
  logic           obs_stall;

  typedef struct {
    logic           v;
    logic [SBW-1:0] sb;
    logic           dss;
    logic           e_stall;
    logic           e_we;
    logic [IDW-1:0] e_waddr;
    logic           e_dsv;
    logic [IDW-1:0] e_dsid;
    logic [SBW-1:0] e_sb;
    int             e_cnt;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    free_q.delete();
    running   = 1'b0;
    init_k    = 0;
    exp_we    = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
    exp_dsv   = 1'b0;
    exp_dsid  = '0;
    exp_dssb  = '0;
    exp_err   = 1'b0;
    for (int i = 0; i < N; i++) alloc_m[i] = 1'b0;
  endtask

  task automatic check_outputs();
    chk("we", we, exp_we);
    chk("waddr", waddr, exp_waddr);
    chk("wdata", wdata, exp_wdata);
    chk("ds_valid", ds_valid, exp_dsv);
    if (exp_dsv) begin
      chk("ds_rayID", ds_rayID, exp_dsid);
      chk("ds_sb_data", ds_sb_data, exp_dssb);
    end
    chk("free_cnt", free_cnt, free_q.size());
    chk("init_done", init_done, running);
    chk("err_double_free", err_double_free, exp_err);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    us_valid   = 1'b0;
    us_ray     = '0;
    us_sb_data = '0;
    ds_stall   = 1'b0;
    free_valid = 1'b0;
    free_rayID = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    chk("us_stall_in_reset", us_stall, 1'b1);
    rst = 1'b0;
  endtask

  // One clock: drive inputs, check us_stall, advance model, check registered outputs after the edge.
  task automatic step(input logic v, input logic [SBW-1:0] sb, input logic dss,
                      input logic fv, input logic [IDW-1:0] fid);
    logic [VW-1:0] r;
    logic m_stall, acc, full, push_ok;
    int id;
    r = VW'({$urandom, $urandom});
    us_valid = v; us_ray = r; us_sb_data = sb; ds_stall = dss;
    free_valid = fv; free_rayID = fid;
    #1;
    m_stall = !running || (free_q.size() == 0) || (exp_dsv && dss);
    obs_stall = us_stall;
    chk("us_stall", us_stall, m_stall);
    acc  = v && !m_stall;
    full = (free_q.size() == N);
    push_ok = 1'b0;
    if (running) begin
      push_ok = fv;
`ifdef RAYSTORE_WRITER_CHK_EN
      if (fv && !alloc_m[fid]) begin
        push_ok = 1'b0;
        exp_err = 1'b1;
      end else if (fv) begin
        alloc_m[fid] = 1'b0;
      end
`endif
      if (full) push_ok = 1'b0;
    end
    if (acc) begin
      id = free_q.pop_front();
      exp_we = 1'b1; exp_waddr = IDW'(id); exp_wdata = r;
      exp_dsv = 1'b1; exp_dsid = IDW'(id); exp_dssb = sb;
      alloc_m[id] = 1'b1;
    end else begin
      exp_we = 1'b0;
      if (!dss) exp_dsv = 1'b0;
    end
    if (push_ok) free_q.push_back(int'(fid));
    if (!running) begin
      free_q.push_back(init_k);
      init_k++;
      if (init_k == N) running = 1'b1;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [IDW-1:0] exp_id;

    //          v  sb     dss stall we waddr dsv id  sb     cnt
    tbl[0]  = '{1, 8'h00, 0,  0,    1, 0,    1,  0,  8'h00, 31};
    tbl[1]  = '{1, 8'h01, 0,  0,    1, 1,    1,  1,  8'h01, 30};
    tbl[2]  = '{1, 8'h02, 0,  0,    1, 2,    1,  2,  8'h02, 29};
    tbl[3]  = '{1, 8'h03, 0,  0,    1, 3,    1,  3,  8'h03, 28};
    tbl[4]  = '{0, 8'h00, 0,  0,    0, 3,    0,  3,  8'h03, 28};
    tbl[5]  = '{1, 8'h10, 0,  0,    1, 4,    1,  4,  8'h10, 27};
    tbl[6]  = '{1, 8'h11, 1,  1,    0, 4,    1,  4,  8'h10, 27};
    tbl[7]  = '{1, 8'h11, 1,  1,    0, 4,    1,  4,  8'h10, 27};
    tbl[8]  = '{1, 8'h11, 1,  1,    0, 4,    1,  4,  8'h10, 27};
    tbl[9]  = '{1, 8'h11, 1,  1,    0, 4,    1,  4,  8'h10, 27};
    tbl[10] = '{1, 8'h11, 1,  1,    0, 4,    1,  4,  8'h10, 27};
    tbl[11] = '{1, 8'h11, 0,  0,    1, 5,    1,  5,  8'h11, 26};
    tbl[12] = '{0, 8'h00, 0,  0,    0, 5,    0,  5,  8'h11, 26};

    do_reset();

    // Initialisation: upstream requests and frees must be ignored for N cycles.
    for (int k = 1; k <= N; k++) begin
      step(1'b1, 8'(k), 1'b0, 1'b1, IDW'(k));
      chk($sformatf("init_stall_%0d", k), obs_stall, 1'b1);
      chk($sformatf("init_done_%0d", k), init_done, (k == N));
    end
    chk("init_free_cnt", free_cnt, N);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v, tbl[i].sb, tbl[i].dss, 1'b0, '0);
      chk($sformatf("tbl%0d_stall", i), obs_stall, tbl[i].e_stall);
      chk($sformatf("tbl%0d_we", i), we, tbl[i].e_we);
      chk($sformatf("tbl%0d_waddr", i), waddr, tbl[i].e_waddr);
      chk($sformatf("tbl%0d_dsv", i), ds_valid, tbl[i].e_dsv);
      if (tbl[i].e_dsv) begin
        chk($sformatf("tbl%0d_dsid", i), ds_rayID, tbl[i].e_dsid);
        chk($sformatf("tbl%0d_dssb", i), ds_sb_data, tbl[i].e_sb);
      end
      chk($sformatf("tbl%0d_cnt", i), free_cnt, tbl[i].e_cnt);
    end

    // Exhaust the free list, then return ID 7: no same-cycle bypass.
    for (int i = 0; i < 40 && free_q.size() != 0; i++) step(1'b1, 8'(i), 1'b0, 1'b0, '0);
    chk("alloc_all_cnt", free_cnt, 0);
    step(1'b1, 8'h9F, 1'b0, 1'b0, '0);
    chk("empty_stall", obs_stall, 1'b1);
    step(1'b1, 8'hA0, 1'b0, 1'b1, IDW'(7));
    chk("free7_stall", obs_stall, 1'b1);
    chk("free7_no_bypass_we", we, 1'b0);
    step(1'b1, 8'hA1, 1'b0, 1'b0, '0);
    chk("realloc7_stall", obs_stall, 1'b0);
    chk("realloc7_we", we, 1'b1);
    chk("realloc7_waddr", waddr, 7);

    // Same-cycle accept and free of ID 3 with ten IDs queued.
    for (int i = 20; i < 30; i++) step(1'b0, '0, 1'b0, 1'b1, IDW'(i));
    chk("cnt10", free_cnt, 10);
    step(1'b1, 8'hB0, 1'b0, 1'b1, IDW'(3));
    chk("pushpop_cnt", free_cnt, 10);
    chk("pushpop_waddr", waddr, 20);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, '0);
      exp_id = (i < 9) ? IDW'(21 + i) : IDW'(3);
      chk($sformatf("reissue_%0d", i), waddr, exp_id);
    end

    // Double free of ID 5.
    step(1'b0, '0, 1'b0, 1'b1, IDW'(5));
    step(1'b0, '0, 1'b0, 1'b1, IDW'(5));
`ifdef RAYSTORE_WRITER_CHK_EN
    chk("dfree_err", err_double_free, 1'b1);
    chk("dfree_cnt", free_cnt, 1);
`else
    chk("dfree_err", err_double_free, 1'b0);
    chk("dfree_cnt", free_cnt, 2);
`endif
    step(1'b0, '0, 1'b0, 1'b0, '0);
`ifdef RAYSTORE_WRITER_CHK_EN
    chk("dfree_sticky", err_double_free, 1'b1);
`else
    chk("dfree_sticky", err_double_free, 1'b0);
`endif

    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 4, IDW'($urandom_range(0, N-1)));
    end

    // Reset mid-run with a ray held downstream.
    step(1'b1, 8'h55, 1'b1, 1'b0, '0);
    do_reset();
    for (int k = 1; k <= N; k++) begin
      step(1'b1, 8'(k), 1'b0, 1'b0, '0);
      chk($sformatf("reinit_stall_%0d", k), obs_stall, 1'b1);
    end
    chk("reinit_done", init_done, 1'b1);
    chk("reinit_cnt", free_cnt, N);
    for (int c = 0; c < 40; c++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 3, IDW'($urandom_range(0, N-1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
